systolic_matmul: RTL

Parametrised output-stationary systolic matrix multiplier computing C = A×B for an M×K by K×P signed fixed-point operand pair. It adds a start/busy/done job handshake, operand capture, built-in skew feeders, per-job accumulator clear, wide accumulation and configurable overflow handling. It sits between the layer sequencer and the activation stage of the neural-network datapath. One multiply job runs at a time.

---
 rtl/systolic_pkg.sv | 59 +++++
 rtl/systolic_pe.sv | 49 ++++
 rtl/systolic_matmul.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic matrix multiplier:
// the FSM state type, sizing helpers and the accumulator-to-result scaler.
// Optional feature macro: SATURATE_EN (clamp out-of-range results and flag
// overflow instead of wrapping).
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } stateT;

  // Accumulator width large enough that K full-precision products never overflow
  function automatic int accWidth(input int n, input int k);
    return 2 * n + $clog2(k);
  endfunction

  // Number of RUN steps needed for the skewed wavefront to cross the array
  function automatic int numSteps(input int m, input int k, input int p);
    return k + m + p - 2;
  endfunction

  // Drop the fractional bits (arithmetic shift, truncation toward -inf) and,
  // when saturation is enabled, clamp into the signed n-bit range
  function automatic logic signed [63:0] scaleAcc(input logic signed [63:0] acc,
                                                  input int n, input int frac);
    logic signed [63:0] r;
`ifdef SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
`endif
    r = acc >>> frac;
`ifdef SATURATE_EN
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
`endif
    return r;
  endfunction

`ifdef SATURATE_EN
  // True when the scaled value does not fit the signed n-bit result range
  function automatic logic accClamps(input logic signed [63:0] acc,
                                     input int n, input int frac);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = acc >>> frac;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    return (r > hi) || (r < lo);
  endfunction
`endif

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the output-stationary array: multiplies the
// operands arriving from west and north, accumulates at full precision and
// forwards both operands one register further east and south.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 34
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [N-1:0]     a_i,
  input  logic signed [N-1:0]     b_i,
  output logic signed [N-1:0]     a_o,
  output logic signed [N-1:0]     b_o,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] accQ;
  logic signed [N-1:0]     aQ;
  logic signed [N-1:0]     bQ;

  assign prod = a_i * b_i;

  // Clear on job accept so stale forwarded operands never leak into a new job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accQ <= '0;
      aQ   <= '0;
      bQ   <= '0;
    end else if (clr_i) begin
      accQ <= '0;
      aQ   <= '0;
      bQ   <= '0;
    end else if (en_i) begin
      accQ <= accQ + ACC_W'(prod);
      aQ   <= a_i;
      bQ   <= b_i;
    end
  end

  assign a_o   = aQ;
  assign b_o   = bQ;
  assign acc_o = accQ;

endmodule

// File: rtl/systolic_matmul.sv
// Output-stationary systolic multiplier C = A x B with start/busy/done job
// handshake, operand capture, skew feeders and result scaling.
// Optional feature macro: SATURATE_EN (saturate results and report ovf;
// otherwise results wrap and ovf stays 0).
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int N    = 16,
  parameter int M    = 4,
  parameter int K    = 4,
  parameter int P    = 4,
  parameter int FRAC = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [M-1:0][K-1:0][N-1:0]    a,
  input  logic [K-1:0][P-1:0][N-1:0]    b,
  output logic                          busy,
  output logic                          done,
  output logic [M-1:0][P-1:0][N-1:0]    c,
  output logic                          ovf
);

  localparam int ACC_W  = accWidth(N, K);
  localparam int T      = numSteps(M, K, P);
  localparam int STEP_W = $clog2(T + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T - 1);

  stateT                       stateQ, stateD;
  logic [STEP_W-1:0]           stepQ, stepD;
  logic [M-1:0][K-1:0][N-1:0]  aQ;
  logic [K-1:0][P-1:0][N-1:0]  bQ;
  logic [M-1:0][P-1:0][N-1:0]  cQ, cD;
  logic                        doneQ;
  logic                        accept;
  logic                        runEn;

  logic signed [N-1:0]     aFeed   [M];
  logic signed [N-1:0]     bFeed   [P];
  logic signed [N-1:0]     aLink   [M][P+1];
  logic signed [N-1:0]     bLink   [M+1][P];
  logic signed [ACC_W-1:0] accArr  [M][P];

  assign accept = (stateQ == ST_IDLE) && start;
  assign runEn  = (stateQ == ST_RUN);

  // Job sequencing: one accepted job walks RUN for T steps, then one OUT cycle
  always_comb begin
    stateD = stateQ;
    stepD  = stepQ;
    case (stateQ)
      ST_IDLE: begin
        if (start) begin
          stateD = ST_RUN;
          stepD  = '0;
        end
      end
      ST_RUN: begin
        if (stepQ == LAST_STEP) begin
          stateD = ST_OUT;
        end else begin
          stepD = stepQ + 1'b1;
        end
      end
      ST_OUT:  stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
  end

  // State, step counter and operand capture on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= ST_IDLE;
      stepQ  <= '0;
      aQ     <= '0;
      bQ     <= '0;
    end else begin
      stateQ <= stateD;
      stepQ  <= stepD;
      if (accept) begin
        aQ <= a;
        bQ <= b;
      end
    end
  end

  // Skew feeders: row i sees A[i][t-i], column j sees B[t-j][j], zero elsewhere
  always_comb begin
    for (int i = 0; i < M; i++) begin
      aFeed[i] = '0;
      for (int k = 0; k < K; k++) begin
        if (int'(stepQ) == i + k) aFeed[i] = aQ[i][k];
      end
    end
    for (int j = 0; j < P; j++) begin
      bFeed[j] = '0;
      for (int k = 0; k < K; k++) begin
        if (int'(stepQ) == j + k) bFeed[j] = bQ[k][j];
      end
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : gRowFeed
    assign aLink[gi][0] = aFeed[gi];
  end
  for (genvar gj = 0; gj < P; gj++) begin : gColFeed
    assign bLink[0][gj] = bFeed[gj];
  end

  for (genvar gi = 0; gi < M; gi++) begin : gRow
    for (genvar gj = 0; gj < P; gj++) begin : gCol
      systolic_pe #(.N(N), .ACC_W(ACC_W)) uPe (
        .clk   (clk),
        .rst   (rst),
        .en_i  (runEn),
        .clr_i (accept),
        .a_i   (aLink[gi][gj]),
        .b_i   (bLink[gi][gj]),
        .a_o   (aLink[gi][gj+1]),
        .b_o   (bLink[gi+1][gj]),
        .acc_o (accArr[gi][gj])
      );
    end
  end

`ifdef SATURATE_EN
  logic ovfQ, ovfD;
`endif

  // Scale every accumulator down to an N-bit result and gather overflow flags
  always_comb begin
    cD = '0;
`ifdef SATURATE_EN
    ovfD = 1'b0;
`endif
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < P; j++) begin
        cD[i][j] = N'(scaleAcc(64'(accArr[i][j]), N, FRAC));
`ifdef SATURATE_EN
        ovfD = ovfD | accClamps(64'(accArr[i][j]), N, FRAC);
`endif
      end
    end
  end

  // Publish results and the done pulse on the OUT -> IDLE edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cQ    <= '0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= (stateQ == ST_OUT);
      if (stateQ == ST_OUT) cQ <= cD;
    end
  end

`ifdef SATURATE_EN
  // Overflow flag follows the same publish edge as c
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfQ <= 1'b0;
    end else if (stateQ == ST_OUT) begin
      ovfQ <= ovfD;
    end
  end
  assign ovf = ovfQ;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (stateQ != ST_IDLE);
  assign done = doneQ;
  assign c    = cQ;

endmodule
